// File: rtl/bip_control_fsm.sv
// BIP multi-cycle control: FETCH/EXEC/HALT with a stallable instruction-memory handshake. Each instruction takes at least 2 cycles.
// FETCH holds o_fetch_req until i_instr_valid arrives. The strobes are decoded from the state and the IR, so a reset clears them at once.
module bip_control_fsm #(
  parameter int NB_INSTRUC = 16,
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_ADDR    = 11,
  parameter int NB_COUNT   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_INSTRUC-1:0] i_instruc,
  input  logic                  i_instr_valid,
  input  logic                  i_acc_zero,
  output logic                  o_fetch_req,
  output logic [NB_ADDR-1:0]    o_addr,
  output logic [NB_OPERAND-1:0] o_operand,
  output logic [1:0]            o_SelA,
  output logic                  o_SelB,
  output logic                  o_WrAcc,
  output logic                  o_op,
  output logic                  o_WrRam,
  output logic                  o_RdRam,
  output logic                  o_halted,
  output logic [NB_COUNT-1:0]   o_retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);
  localparam logic [NB_OPCODE-1:0] OP_BEQ  = NB_OPCODE'(8);
  localparam logic [NB_OPCODE-1:0] OP_BNE  = NB_OPCODE'(9);
  localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(10);

  state_t                  state_q, state_d;
  logic [NB_ADDR-1:0]      pc_q, pc_d;
  logic [NB_INSTRUC-1:0]   ir_q, ir_d;
  logic [NB_COUNT-1:0]     ret_q, ret_d;

  logic [NB_OPCODE-1:0]    opcode;
  logic [NB_OPERAND-1:0]   operand;
  logic [NB_ADDR-1:0]      pc_inc;
  logic [NB_ADDR-1:0]      target;

  assign opcode  = ir_q[NB_INSTRUC-1 -: NB_OPCODE];
  assign operand = ir_q[NB_OPERAND-1:0];
  assign pc_inc  = pc_q + NB_ADDR'(1);

  generate
    if (NB_OPERAND >= NB_ADDR) begin : g_tgt_trunc
      assign target = operand[NB_ADDR-1:0];
    end else begin : g_tgt_zext
      assign target = {{(NB_ADDR-NB_OPERAND){1'b0}}, operand};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ret_d       = ret_q;
    o_fetch_req = 1'b0;
    o_halted    = 1'b0;
    o_SelA      = 2'b00;
    o_SelB      = 1'b0;
    o_WrAcc     = 1'b0;
    o_op        = 1'b0;
    o_WrRam     = 1'b0;
    o_RdRam     = 1'b0;

    case (state_q)
      S_FETCH: begin
        o_fetch_req = 1'b1;
        if (i_instr_valid) begin
          ir_d    = i_instruc;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        ret_d   = ret_q + NB_COUNT'(1);
        pc_d    = pc_inc;
        case (opcode)
          OP_HLT: begin
            // The halting instruction itself is not retired and leaves the pc where it is
            state_d = S_HALT;
            ret_d   = ret_q;
            pc_d    = pc_q;
          end
          OP_STO:  o_WrRam = 1'b1;
          OP_LD: begin
            o_RdRam = 1'b1;
            o_WrAcc = 1'b1;
          end
          OP_LDI: begin
            o_SelA  = 2'b01;
            o_WrAcc = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_RdRam = 1'b1;
            o_op    = (opcode == OP_SUB);
            o_SelA  = 2'b10;
            o_WrAcc = 1'b1;
          end
          OP_ADDI, OP_SUBI: begin
            o_SelB  = 1'b1;
            o_op    = (opcode == OP_SUBI);
            o_SelA  = 2'b10;
            o_WrAcc = 1'b1;
          end
          OP_BEQ:  if (i_acc_zero)  pc_d = target;
          OP_BNE:  if (!i_acc_zero) pc_d = target;
          OP_JMP:  pc_d = target;
          default: ;
        endcase
      end

      S_HALT: o_halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

  assign o_addr    = pc_q;
  assign o_operand = operand;
  assign o_retired = ret_q;

endmodule

// File: tb/tb_bip_control_fsm.sv
// Directed bench for bip_control_fsm: the stimulus queues the hand-computed response of each instruction.
// A monitor pops one entry per EXEC cycle and checks the strobes, then the pc, counter and halt state after the cycle.
module tb_bip_control_fsm;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_instruc;
  logic        i_instr_valid;
  logic        i_acc_zero;
  logic        o_fetch_req;
  logic [10:0] o_addr;
  logic [10:0] o_operand;
  logic [1:0]  o_SelA;
  logic        o_SelB;
  logic        o_WrAcc;
  logic        o_op;
  logic        o_WrRam;
  logic        o_RdRam;
  logic        o_halted;
  logic [15:0] o_retired;

  bip_control_fsm dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_instruc     (i_instruc),
    .i_instr_valid (i_instr_valid),
    .i_acc_zero    (i_acc_zero),
    .o_fetch_req   (o_fetch_req),
    .o_addr        (o_addr),
    .o_operand     (o_operand),
    .o_SelA        (o_SelA),
    .o_SelB        (o_SelB),
    .o_WrAcc       (o_WrAcc),
    .o_op          (o_op),
    .o_WrRam       (o_WrRam),
    .o_RdRam       (o_RdRam),
    .o_halted      (o_halted),
    .o_retired     (o_retired)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Strobe order: {SelA[1:0], SelB, WrAcc, op, WrRam, RdRam}
  logic [6:0] strb;
  assign strb = {o_SelA, o_SelB, o_WrAcc, o_op, o_WrRam, o_RdRam};

  typedef struct packed {
    logic [6:0]  strb;
    logic [10:0] opnd;
    logic [10:0] pc_nx;
    logic [15:0] ret_nx;
    logic        halt_nx;
  } exp_t;

  exp_t        sb_q[$];
  int          tests  = 0;
  int          fails  = 0;
  logic [10:0] exp_pc = '0;
  logic [15:0] exp_ret = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // An EXEC cycle is the only state with both fetch_req and halted low
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst && !o_fetch_req && !o_halted) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_exec", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("exec_strobes", {25'd0, strb}, {25'd0, e.strb});
          chk("exec_operand", {21'd0, o_operand}, {21'd0, e.opnd});
          @(posedge i_clk);
          #2;
          chk("pc_after", {21'd0, o_addr}, {21'd0, e.pc_nx});
          chk("retired_after", {16'd0, o_retired}, {16'd0, e.ret_nx});
          chk("halted_after", {31'd0, o_halted}, {31'd0, e.halt_nx});
        end
      end
    end
  end

  // Stalls for the given number of FETCH cycles, then presents the instruction. The input then stays valid
  // through EXEC with a HLT word on the bus, which the DUT must ignore.
  task automatic issue(input logic [15:0] ins, input logic az, input int stall,
                       input logic [6:0] s, input logic [10:0] pc_nx, input logic counted,
                       input logic halt_nx);
    exp_t e;
    for (int k = 0; k < stall; k++) begin
      i_instr_valid = 1'b0;
      i_instruc     = 16'h1FFF;
      @(posedge i_clk);
      #1;
      chk("stall_fetch_req", {31'd0, o_fetch_req}, 32'd1);
      chk("stall_pc", {21'd0, o_addr}, {21'd0, exp_pc});
      chk("stall_strobes", {25'd0, strb}, 32'd0);
    end
    if (counted) exp_ret = exp_ret + 16'd1;
    e.strb = s; e.opnd = ins[10:0]; e.pc_nx = pc_nx; e.ret_nx = exp_ret; e.halt_nx = halt_nx;
    sb_q.push_back(e);
    exp_pc        = pc_nx;
    i_instruc     = ins;
    i_acc_zero    = az;
    i_instr_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_instruc = 16'h0000;
    @(posedge i_clk);
    #1;
    i_instr_valid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b0; i_instruc = '0; i_instr_valid = 1'b0; i_acc_zero = 1'b0;
    #12;
    chk("rst_fetch_req", {31'd0, o_fetch_req}, 32'd1);
    chk("rst_addr", {21'd0, o_addr}, 32'd0);
    chk("rst_retired", {16'd0, o_retired}, 32'd0);
    chk("rst_halted", {31'd0, o_halted}, 32'd0);
    chk("rst_strobes", {25'd0, strb}, 32'd0);
    chk("rst_operand", {21'd0, o_operand}, 32'd0);
    @(posedge i_clk); #1; i_rst = 1'b1;

    //     instr     az   stall strobes      pc_next  cnt halt
    issue(16'h1805, 1'b0, 0, 7'b01_0_1_0_0_0, 11'h001, 1, 0); // LDI 5
    issue(16'h0807, 1'b0, 4, 7'b00_0_0_0_1_0, 11'h002, 1, 0); // STO 7
    issue(16'h1003, 1'b0, 0, 7'b00_0_1_0_0_1, 11'h003, 1, 0); // LD 3
    issue(16'h2801, 1'b0, 1, 7'b10_1_1_0_0_0, 11'h004, 1, 0); // ADDI 1
    issue(16'h3002, 1'b0, 0, 7'b10_0_1_1_0_1, 11'h005, 1, 0); // SUB 2
    issue(16'h3809, 1'b0, 0, 7'b10_1_1_1_0_0, 11'h006, 1, 0); // SUBI 9
    issue(16'h4020, 1'b1, 0, 7'b00_0_0_0_0_0, 11'h020, 1, 0); // BEQ taken
    issue(16'h4100, 1'b0, 0, 7'b00_0_0_0_0_0, 11'h021, 1, 0); // BEQ not taken
    issue(16'h4850, 1'b0, 0, 7'b00_0_0_0_0_0, 11'h050, 1, 0); // BNE taken
    issue(16'h4850, 1'b1, 0, 7'b00_0_0_0_0_0, 11'h051, 1, 0); // BNE not taken
    issue(16'h78AA, 1'b0, 0, 7'b00_0_0_0_0_0, 11'h052, 1, 0); // NOP (opcode 01111)
    issue(16'h57FF, 1'b0, 0, 7'b00_0_0_0_0_0, 11'h7FF, 1, 0); // JMP 0x7FF
    issue(16'h2003, 1'b0, 0, 7'b10_0_1_0_0_1, 11'h000, 1, 0); // ADD 3, pc wraps
    issue(16'h5123, 1'b0, 0, 7'b00_0_0_0_0_0, 11'h123, 1, 0); // JMP 0x123
    issue(16'h0012, 1'b0, 0, 7'b00_0_0_0_0_0, 11'h123, 0, 1); // HLT

    i_instr_valid = 1'b1; i_instruc = 16'h1805;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      chk("halt_halted", {31'd0, o_halted}, 32'd1);
      chk("halt_fetch_req", {31'd0, o_fetch_req}, 32'd0);
      chk("halt_pc", {21'd0, o_addr}, 32'h123);
      chk("halt_retired", {16'd0, o_retired}, 32'd14);
    end
    i_instr_valid = 1'b0;
    #3 i_rst = 1'b0;
    #1;
    chk("halt_rst_halted", {31'd0, o_halted}, 32'd0);
    chk("halt_rst_fetch_req", {31'd0, o_fetch_req}, 32'd1);
    chk("halt_rst_pc", {21'd0, o_addr}, 32'd0);
    chk("halt_rst_retired", {16'd0, o_retired}, 32'd0);
    exp_pc = '0; exp_ret = '0;
    @(posedge i_clk); #1; i_rst = 1'b1;

    issue(16'h1801, 1'b0, 0, 7'b01_0_1_0_0_0, 11'h001, 1, 0); // LDI 1

    // STO is checked directly here because the reset removes its EXEC cycle before the monitor samples it
    i_instruc = 16'h0804; i_instr_valid = 1'b1;
    @(posedge i_clk); #1;
    i_instr_valid = 1'b0;
    chk("sto_exec_wrram", {31'd0, o_WrRam}, 32'd1);
    chk("sto_exec_pc", {21'd0, o_addr}, 32'd1);
    #1 i_rst = 1'b0;
    #1;
    chk("sto_rst_wrram", {31'd0, o_WrRam}, 32'd0);
    chk("sto_rst_pc", {21'd0, o_addr}, 32'd0);
    chk("sto_rst_retired", {16'd0, o_retired}, 32'd0);
    chk("sto_rst_fetch_req", {31'd0, o_fetch_req}, 32'd1);
    exp_pc = '0; exp_ret = '0;
    @(posedge i_clk); #1; i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("sto_rst_pc_held", {21'd0, o_addr}, 32'd0);

    issue(16'h1806, 1'b0, 2, 7'b01_0_1_0_0_0, 11'h001, 1, 0); // LDI 6 after reset

    repeat (3) @(posedge i_clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
